// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared constants and FSM state type for the data memory
package data_memory_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_lane_align.sv
// rtl/data_memory_lane_align.sv - byte-lane steering for stores and load extension
module dmem_lane_align
    import data_memory_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  store_size,
    input  logic [31:0] store_data,
    input  logic [2:0]  load_funct3,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_result
);

    logic [31:0] byte_shifted;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        byte_en    = 4'b1111;
        store_word = store_data;
        case (store_size)
            SZ_B: begin
                byte_en    = 4'b0001 << addr_lo;
                store_word = {4{store_data[7:0]}};
            end
            SZ_H: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_word = store_data;
            end
        endcase
    end

    // Halfword loads ignore address[0], matching the store lane choice.
    always_comb begin
        byte_shifted = load_word >> {addr_lo, 3'b000};
        load_byte    = byte_shifted[7:0];
        load_half    = addr_lo[1] ? load_word[31:16] : load_word[15:0];
        case (load_funct3)
            F3_LB:   load_result = {{24{load_byte[7]}}, load_byte};
            F3_LH:   load_result = {{16{load_half[15]}}, load_half};
            F3_LBU:  load_result = {24'h000000, load_byte};
            F3_LHU:  load_result = {16'h0000, load_half};
            default: load_result = load_word;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-addressable data memory with busywait latency handshake
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  read,
    input  logic [2:0]  write,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait,
    output logic [31:0] DEBUG_DATA,
    output logic        DEBUG_READ_ACC,
    output logic        DEBUG_WRITE_ACC
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0] mem [DEPTH];

    state_t                 state, state_next;
    logic [15:0]            count;
    logic [ADDR_BITS-1:0]   req_index;
    logic [1:0]             req_lo;
    logic [31:0]            req_data;
    logic                   req_is_write;
    logic [2:0]             req_funct3;
    logic [1:0]             req_size;

    logic        request, commit;
    logic [31:0] current_word, merged_word, store_word, load_result;
    logic [3:0]  byte_en;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^address[31:ADDR_BITS+2];
    assign request          = read[3] | write[2];
    assign commit           = (state == BUSY) && (count == 16'(ACCESS_CYCLES));
    assign current_word     = mem[req_index];
    assign busywait         = !reset && (((state == IDLE) && request) || (state == BUSY));

    dmem_lane_align u_align (
        .addr_lo     (req_lo),
        .store_size  (req_size),
        .store_data  (req_data),
        .load_funct3 (req_funct3),
        .load_word   (current_word),
        .byte_en     (byte_en),
        .store_word  (store_word),
        .load_result (load_result)
    );

    always_comb begin
        merged_word = current_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) merged_word[8*i +: 8] = store_word[8*i +: 8];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (request) state_next = BUSY;
            BUSY:    if (commit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write has priority over read when both enables are high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            count           <= 16'd0;
            req_index       <= '0;
            req_lo          <= 2'b00;
            req_data        <= 32'h0;
            req_is_write    <= 1'b0;
            req_funct3      <= 3'b000;
            req_size        <= 2'b00;
            readdata        <= 32'h0;
            DEBUG_DATA      <= 32'h0;
            DEBUG_READ_ACC  <= 1'b0;
            DEBUG_WRITE_ACC <= 1'b0;
        end else begin
            state           <= state_next;
            DEBUG_READ_ACC  <= 1'b0;
            DEBUG_WRITE_ACC <= 1'b0;
            if (state == IDLE && request) begin
                count        <= 16'd1;
                req_index    <= address[ADDR_BITS+1:2];
                req_lo       <= address[1:0];
                req_data     <= writedata;
                req_is_write <= write[2];
                req_funct3   <= read[2:0];
                req_size     <= write[1:0];
            end else if (state == BUSY) begin
                count <= count + 16'd1;
            end
            if (commit) begin
                if (req_is_write) begin
                    DEBUG_DATA      <= merged_word;
                    DEBUG_WRITE_ACC <= 1'b1;
                end else begin
                    readdata       <= load_result;
                    DEBUG_DATA     <= current_word;
                    DEBUG_READ_ACC <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else if (commit && req_is_write) begin
            mem[req_index] <= merged_word;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed self-checking bench for data_memory
module tb_data_memory;

    localparam int ADDR_BITS     = 8;
    localparam int ACCESS_CYCLES = 1;
    localparam int DEPTH         = 1 << ADDR_BITS;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  read = 4'b0;
    logic [2:0]  write = 3'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata, DEBUG_DATA;
    logic        busywait, DEBUG_READ_ACC, DEBUG_WRITE_ACC;

    data_memory #(.ADDR_BITS(ADDR_BITS), .ACCESS_CYCLES(ACCESS_CYCLES)) dut (
        .clock           (clock),
        .reset           (reset),
        .read            (read),
        .write           (write),
        .address         (address),
        .writedata       (writedata),
        .readdata        (readdata),
        .busywait        (busywait),
        .DEBUG_DATA      (DEBUG_DATA),
        .DEBUG_READ_ACC  (DEBUG_READ_ACC),
        .DEBUG_WRITE_ACC (DEBUG_WRITE_ACC)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int busy_cycles = 0;
    bit cmp_en = 1'b0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] exp_dbg = 32'h0;
    logic        exp_busy = 1'b0;
    logic        exp_rpulse = 1'b0;
    logic        exp_wpulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            check("busywait", {31'b0, busywait}, {31'b0, exp_busy});
            check("read_acc", {31'b0, DEBUG_READ_ACC}, {31'b0, exp_rpulse});
            check("write_acc", {31'b0, DEBUG_WRITE_ACC}, {31'b0, exp_wpulse});
            check("readdata", readdata, exp_rdata);
            check("debug_data", DEBUG_DATA, exp_dbg);
            if (busywait === 1'b1) busy_cycles++;
        end
    end

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        exp_rdata  = 32'h0;
        exp_dbg    = 32'h0;
        exp_busy   = 1'b0;
        exp_rpulse = 1'b0;
        exp_wpulse = 1'b0;
    endfunction

    // Little-endian memory model using plain masks and shifts on the byte address.
    function automatic void model_apply(input logic [3:0] rd, input logic [2:0] wr,
                                        input logic [31:0] a, input logic [31:0] wd);
        int unsigned idx, sh;
        logic [31:0] old, mask, val, b, h;
        idx = (a / 4) % DEPTH;
        old = model_mem[idx];
        if (wr[2]) begin
            if (wr[1:0] == 2'b00) begin
                sh = 8 * (a % 4);
                mask = 32'hFF << sh;
                val = (wd & 32'hFF) << sh;
            end else if (wr[1:0] == 2'b01) begin
                sh = 16 * ((a / 2) % 2);
                mask = 32'hFFFF << sh;
                val = (wd & 32'hFFFF) << sh;
            end else begin
                mask = 32'hFFFFFFFF;
                val = wd;
            end
            model_mem[idx] = (old & ~mask) | val;
            exp_dbg = model_mem[idx];
            exp_wpulse = 1'b1;
        end else if (rd[3]) begin
            b = (old >> (8 * (a % 4))) & 32'hFF;
            h = (old >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            case (rd[2:0])
                3'b000:  exp_rdata = (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
                3'b001:  exp_rdata = (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
                3'b100:  exp_rdata = b;
                3'b101:  exp_rdata = h;
                default: exp_rdata = old;
            endcase
            exp_dbg = old;
            exp_rpulse = 1'b1;
        end
        exp_busy = 1'b0;
    endfunction

    task automatic access(input logic [3:0] rd, input logic [2:0] wr,
                          input logic [31:0] a, input logic [31:0] wd);
        @(posedge clock); #1;
        read = rd; write = wr; address = a; writedata = wd;
        exp_busy = 1'b1; exp_rpulse = 1'b0; exp_wpulse = 1'b0;
        @(posedge clock); #1;
        read = 4'b0; write = 3'b0; address = $urandom; writedata = $urandom;
        repeat (ACCESS_CYCLES) @(posedge clock);
        #1;
        model_apply(rd, wr, a, wd);
        @(posedge clock); #1;
        exp_rpulse = 1'b0; exp_wpulse = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        model_clear();
        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_debug_data", DEBUG_DATA, 32'h0);
        check("rst_busywait", {31'b0, busywait}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        @(posedge clock); #1;
        cmp_en = 1'b1;
        check("init_readdata", readdata, 32'h0);
        check("init_pulses", {30'b0, DEBUG_READ_ACC, DEBUG_WRITE_ACC}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        busy_cycles = 0;
        access(4'b0000, 3'b110, 32'h04, 32'hAABBCCDD);
        check("sw_busy_cycles", busy_cycles, 32'd2);
        check("sw_debug_data", DEBUG_DATA, 32'hAABBCCDD);
        access(4'b1010, 3'b000, 32'h04, 32'h0);
        check("lw_04", readdata, 32'hAABBCCDD);

        access(4'b0000, 3'b100, 32'h08, 32'hAABBCCDD);
        access(4'b1010, 3'b000, 32'h08, 32'h0);
        check("lw_08", readdata, 32'h000000DD);
        access(4'b1000, 3'b000, 32'h08, 32'h0);
        check("lb_08", readdata, 32'hFFFFFFDD);
        access(4'b1100, 3'b000, 32'h08, 32'h0);
        check("lbu_08", readdata, 32'h000000DD);

        access(4'b0000, 3'b101, 32'h0E, 32'h11223344);
        access(4'b1010, 3'b000, 32'h0C, 32'h0);
        check("lw_0c", readdata, 32'h33440000);
        access(4'b1001, 3'b000, 32'h0E, 32'h0);
        check("lh_0e", readdata, 32'h00003344);
        access(4'b0000, 3'b101, 32'h0E, 32'h00008001);
        access(4'b1001, 3'b000, 32'h0E, 32'h0);
        check("lh_0e_neg", readdata, 32'hFFFF8001);
        access(4'b1101, 3'b000, 32'h0E, 32'h0);
        check("lhu_0e", readdata, 32'h00008001);

        do_reset();
        access(4'b1010, 3'b000, 32'h10, 32'h0);
        check("lw_10_after_rst", readdata, 32'h0);
        access(4'b1010, 3'b000, 32'h04, 32'h0);
        check("lw_04_cleared", readdata, 32'h0);

        @(posedge clock); #1;
        read = 4'b0; write = 3'b110; address = 32'h20; writedata = 32'h12345678;
        exp_busy = 1'b1;
        @(posedge clock); #1;
        write = 3'b0;
        reset = 1'b1;
        model_clear();
        #1;
        check("busy_rst_busywait", {31'b0, busywait}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        access(4'b1010, 3'b000, 32'h20, 32'h0);
        check("lw_20_abandoned", readdata, 32'h0);

        access(4'b0000, 3'b110, 32'h44, 32'h55AA55AA);
        access(4'b1010, 3'b000, 32'h44, 32'h0);
        access(4'b1010, 3'b110, 32'h40, 32'hCAFEF00D);
        check("rw_readdata_held", readdata, 32'h55AA55AA);
        check("rw_debug_data", DEBUG_DATA, 32'hCAFEF00D);
        access(4'b1010, 3'b000, 32'h40 + (32'd4 << ADDR_BITS), 32'h0);
        check("lw_wrap", readdata, 32'hCAFEF00D);

        access(4'b1011, 3'b000, 32'h40, 32'h0);
        check("f3_011_as_lw", readdata, 32'hCAFEF00D);

        @(posedge clock); #1;
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
